// File: rtl/cgp_eval_pkg.sv
// Shared types and sizing helpers for the CGP exhaustive fitness evaluators.
package cgp_eval_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWEEP  = 2'd1,
        DRAIN  = 2'd2,
        DONE_P = 2'd3
    } eval_state_e;

    // Squarer benchmark: 5-bit operand, 8 kept output bits
    localparam int unsigned SQ_N_IN  = 5;
    localparam int unsigned SQ_N_OUT = 8;

    // Width that holds 2^n_in * n_out without overflow
    function automatic int unsigned err_w(input int unsigned n_in, input int unsigned n_out);
        return n_in + $clog2(n_out + 1);
    endfunction

endpackage

// File: rtl/exhaustive_fitness_evaluator_if.sv
// Harness-side bundle: sweep control, candidate/golden responses and fitness results.
interface exhaustive_fitness_evaluator_if
    import cgp_eval_pkg::*;
#(
    parameter int unsigned N_IN  = SQ_N_IN,
    parameter int unsigned N_OUT = SQ_N_OUT
);
    localparam int unsigned ERR_W = err_w(N_IN, N_OUT);

    logic              start;
    logic [N_IN-1:0]   dut_in;
    logic [N_OUT-1:0]  dut_out;
    logic [N_OUT-1:0]  ref_out;
    logic              busy;
    logic              done;
    logic [ERR_W-1:0]  err_count;
    logic [N_OUT-1:0]  err_mask;
    logic              perfect;

    // Evaluator side
    modport master (
        input  start, dut_out, ref_out,
        output dut_in, busy, done, err_count, err_mask, perfect
    );

    // Environment side: launches sweeps, hosts candidate and golden circuits
    modport slave (
        output start, dut_out, ref_out,
        input  dut_in, busy, done, err_count, err_mask, perfect
    );

endinterface

// File: rtl/popcount_n.sv
// Combinational population count of a W-bit vector.
module popcount_n #(
    parameter int unsigned W = 8,
    localparam int unsigned CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  vec,
    output logic [CW-1:0] count_c
);

    always_comb begin
        count_c = '0;
        for (int i = 0; i < W; i++) begin
            count_c = count_c + CW'(vec[i]);
        end
    end

endmodule

// File: rtl/exhaustive_fitness_evaluator.sv
// Sweeps every input vector through a candidate circuit and accumulates Hamming
// error against the golden netlist: total count, per-bit mask and perfect flag.
module exhaustive_fitness_evaluator
    import cgp_eval_pkg::*;
#(
    parameter int unsigned N_IN  = SQ_N_IN,
    parameter int unsigned N_OUT = SQ_N_OUT,
    parameter int unsigned PIPE  = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    exhaustive_fitness_evaluator_if.master  bus
);

    localparam int unsigned ERR_W = err_w(N_IN, N_OUT);
    localparam int unsigned CW    = $clog2(N_OUT + 1);
    localparam logic [N_IN-1:0] LAST_VEC = '1;

    eval_state_e       state;
    logic [N_IN-1:0]   vec;
    logic              busy;
    logic              done;
    logic [ERR_W-1:0]  err_count;
    logic [N_OUT-1:0]  err_mask;
    logic              perfect;

    logic [N_OUT-1:0]  diff_c;
    logic              acc_en_c;
    logic [CW-1:0]     ones_c;
    logic [ERR_W-1:0]  count_next_c;
    logic [N_OUT-1:0]  mask_next_c;

    // Operand source: live responses, or a registered pair one vector behind
    if (PIPE != 0) begin : g_pipe
        logic [N_OUT-1:0] cap_out;
        logic [N_OUT-1:0] cap_ref;
        logic             cap_vld;

        always_ff @(posedge clk) begin
            if (rst) begin
                cap_out <= '0;
                cap_ref <= '0;
                cap_vld <= 1'b0;
            end else begin
                cap_vld <= (state == SWEEP);
                if (state == SWEEP) begin
                    cap_out <= bus.dut_out;
                    cap_ref <= bus.ref_out;
                end
            end
        end

        assign diff_c   = cap_out ^ cap_ref;
        assign acc_en_c = cap_vld && ((state == SWEEP) || (state == DRAIN));
    end else begin : g_direct
        assign diff_c   = bus.dut_out ^ bus.ref_out;
        assign acc_en_c = (state == SWEEP);
    end

    popcount_n #(.W(N_OUT)) u_popcount (
        .vec     (diff_c),
        .count_c (ones_c)
    );

    assign count_next_c = acc_en_c ? (err_count + ERR_W'(ones_c)) : err_count;
    assign mask_next_c  = acc_en_c ? (err_mask | diff_c) : err_mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            vec       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_count <= '0;
            err_mask  <= '0;
            perfect   <= 1'b0;
        end else begin
            done      <= 1'b0;
            err_count <= count_next_c;
            err_mask  <= mask_next_c;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        err_count <= '0;
                        err_mask  <= '0;
                        perfect   <= 1'b0;
                        vec       <= '0;
                        busy      <= 1'b1;
                        state     <= SWEEP;
                    end
                end
                SWEEP: begin
                    // Counter parks on the last vector until the next start
                    if (vec == LAST_VEC) begin
                        if (PIPE != 0) begin
                            state <= DRAIN;
                        end else begin
                            state   <= DONE_P;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            perfect <= (count_next_c == '0);
                        end
                    end else begin
                        vec <= vec + N_IN'(1);
                    end
                end
                DRAIN: begin
                    state   <= DONE_P;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    perfect <= (count_next_c == '0);
                end
                DONE_P: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.dut_in    = vec;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.err_count = err_count;
    assign bus.err_mask  = err_mask;
    assign bus.perfect   = perfect;

endmodule

// File: tb/tb_exhaustive_fitness_evaluator.sv
// Directed bench: one evaluator with direct compare, one with registered compare.
module tb_exhaustive_fitness_evaluator;

    logic clk;
    logic rst;
    logic [1:0] mode0;
    logic [1:0] mode1;
    int tests_run;
    int tests_failed;

    exhaustive_fitness_evaluator_if #(.N_IN(5), .N_OUT(8)) if0 ();
    exhaustive_fitness_evaluator_if #(.N_IN(5), .N_OUT(8)) if1 ();

    exhaustive_fitness_evaluator #(.N_IN(5), .N_OUT(8), .PIPE(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    exhaustive_fitness_evaluator #(.N_IN(5), .N_OUT(8), .PIPE(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    // mode 0: exact squarer, 1: LSB stuck at 1, 2: candidate echoes its input
    function automatic logic [7:0] cand(input logic [1:0] m, input logic [4:0] v);
        logic [9:0] sq;
        sq = 10'(v) * 10'(v);
        case (m)
            2'd0:    return sq[7:0];
            2'd1:    return 8'h01;
            default: return {3'b000, v};
        endcase
    endfunction

    function automatic logic [7:0] gold(input logic [1:0] m, input logic [4:0] v);
        logic [9:0] sq;
        sq = 10'(v) * 10'(v);
        return (m == 2'd0) ? sq[7:0] : 8'h00;
    endfunction

    assign if0.dut_out = cand(mode0, if0.dut_in);
    assign if0.ref_out = gold(mode0, if0.dut_in);
    assign if1.dut_out = cand(mode1, if1.dut_in);
    assign if1.ref_out = gold(mode1, if1.dut_in);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycles from the current cycle until done is seen, -1 on timeout
    task automatic wait_done(input bit which, output int lat);
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            tick();
            if ((which ? if1.done : if0.done) === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic accept0();
        if0.start = 1'b1;
        tick();
        if0.start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tests_run++;
        if (if0.dut_in !== 5'd0) begin tests_failed++; $display("FAIL reset_dut_in0: got %0d want 0", if0.dut_in); end
        tests_run++;
        if (if0.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy0: got %b want 0", if0.busy); end
        tests_run++;
        if (if0.done !== 1'b0) begin tests_failed++; $display("FAIL reset_done0: got %b want 0", if0.done); end
        tests_run++;
        if (if0.err_count !== 9'd0) begin tests_failed++; $display("FAIL reset_err0: got %0d want 0", if0.err_count); end
        tests_run++;
        if (if0.err_mask !== 8'h00) begin tests_failed++; $display("FAIL reset_mask0: got %h want 00", if0.err_mask); end
        tests_run++;
        if (if0.perfect !== 1'b0) begin tests_failed++; $display("FAIL reset_perfect0: got %b want 0", if0.perfect); end
        tests_run++;
        if (if1.busy !== 1'b0 || if1.done !== 1'b0 || if1.perfect !== 1'b0)
            begin tests_failed++; $display("FAIL reset_flags1: got busy=%b done=%b perfect=%b want 000", if1.busy, if1.done, if1.perfect); end
        tests_run++;
        if (if1.err_count !== 9'd0 || if1.dut_in !== 5'd0)
            begin tests_failed++; $display("FAIL reset_vals1: got err=%0d dut_in=%0d want 0 0", if1.err_count, if1.dut_in); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_perfect();
        int lat;
        mode0 = 2'd0;
        accept0();
        tests_run++;
        if (if0.busy !== 1'b1 || if0.done !== 1'b0)
            begin tests_failed++; $display("FAIL perfect_accept: got busy=%b done=%b want 1 0", if0.busy, if0.done); end
        wait_done(1'b0, lat);
        tests_run++;
        if (lat !== 32) begin tests_failed++; $display("FAIL perfect_latency: got %0d want 32", lat); end
        tests_run++;
        if (if0.busy !== 1'b0) begin tests_failed++; $display("FAIL perfect_busy_at_done: got %b want 0", if0.busy); end
        tests_run++;
        if (if0.err_count !== 9'd0) begin tests_failed++; $display("FAIL perfect_err: got %0d want 0", if0.err_count); end
        tests_run++;
        if (if0.err_mask !== 8'h00) begin tests_failed++; $display("FAIL perfect_mask: got %h want 00", if0.err_mask); end
        tests_run++;
        if (if0.perfect !== 1'b1) begin tests_failed++; $display("FAIL perfect_flag: got %b want 1", if0.perfect); end
        tick();
        tests_run++;
        if (if0.done !== 1'b0 || if0.perfect !== 1'b1)
            begin tests_failed++; $display("FAIL perfect_pulse_hold: got done=%b perfect=%b want 0 1", if0.done, if0.perfect); end
        tick();
    endtask

    task automatic test_const_err();
        int lat;
        mode0 = 2'd1;
        accept0();
        tests_run++;
        if (if0.perfect !== 1'b0) begin tests_failed++; $display("FAIL const_perfect_cleared: got %b want 0", if0.perfect); end
        wait_done(1'b0, lat);
        tests_run++;
        if (lat !== 32) begin tests_failed++; $display("FAIL const_latency: got %0d want 32", lat); end
        tests_run++;
        if (if0.err_count !== 9'd32) begin tests_failed++; $display("FAIL const_err: got %0d want 32", if0.err_count); end
        tests_run++;
        if (if0.err_mask !== 8'h01) begin tests_failed++; $display("FAIL const_mask: got %h want 01", if0.err_mask); end
        tests_run++;
        if (if0.perfect !== 1'b0) begin tests_failed++; $display("FAIL const_perfect: got %b want 0", if0.perfect); end
        tick();
        tick();
    endtask

    task automatic test_ramp();
        int bad;
        mode0 = 2'd2;
        accept0();
        bad = 0;
        for (int k = 0; k < 32; k++) begin
            if (if0.dut_in !== 5'(k) || if0.done !== 1'b0) bad++;
            tick();
        end
        tests_run++;
        if (bad !== 0) begin tests_failed++; $display("FAIL ramp_dut_in_steps: got %0d bad cycles want 0", bad); end
        tests_run++;
        if (if0.done !== 1'b1) begin tests_failed++; $display("FAIL ramp_done_cycle32: got %b want 1", if0.done); end
        tests_run++;
        if (if0.err_count !== 9'd80) begin tests_failed++; $display("FAIL ramp_err: got %0d want 80", if0.err_count); end
        tests_run++;
        if (if0.err_mask !== 8'h1F) begin tests_failed++; $display("FAIL ramp_mask: got %h want 1f", if0.err_mask); end
        tick();
        tick();
        tests_run++;
        if (if0.dut_in !== 5'd31 || if0.err_count !== 9'd80)
            begin tests_failed++; $display("FAIL ramp_hold: got dut_in=%0d err=%0d want 31 80", if0.dut_in, if0.err_count); end
    endtask

    task automatic test_rst_mid();
        int lat;
        int seen;
        mode0 = 2'd2;
        accept0();
        for (int k = 0; k < 10; k++) tick();
        tests_run++;
        if (if0.dut_in !== 5'd10) begin tests_failed++; $display("FAIL rst_pre_dut_in: got %0d want 10", if0.dut_in); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if (if0.busy !== 1'b0 || if0.done !== 1'b0)
            begin tests_failed++; $display("FAIL rst_flags: got busy=%b done=%b want 0 0", if0.busy, if0.done); end
        tests_run++;
        if (if0.dut_in !== 5'd0 || if0.err_count !== 9'd0 || if0.err_mask !== 8'h00)
            begin tests_failed++; $display("FAIL rst_vals: got dut_in=%0d err=%0d mask=%h want 0 0 00", if0.dut_in, if0.err_count, if0.err_mask); end
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (if0.done !== 1'b0 || if0.busy !== 1'b0) seen++;
        end
        tests_run++;
        if (seen !== 0) begin tests_failed++; $display("FAIL rst_no_done: got %0d active cycles want 0", seen); end
        accept0();
        wait_done(1'b0, lat);
        tests_run++;
        if (lat !== 32 || if0.err_count !== 9'd80)
            begin tests_failed++; $display("FAIL rst_resweep: got lat=%0d err=%0d want 32 80", lat, if0.err_count); end
        tick();
        tick();
        rst = 1'b1;
        if0.start = 1'b1;
        tick();
        rst = 1'b0;
        if0.start = 1'b0;
        tests_run++;
        if (if0.busy !== 1'b0 || if0.err_count !== 9'd0)
            begin tests_failed++; $display("FAIL rst_beats_start: got busy=%b err=%0d want 0 0", if0.busy, if0.err_count); end
        tick();
        tests_run++;
        if (if0.busy !== 1'b0) begin tests_failed++; $display("FAIL rst_start_stays_idle: got %b want 0", if0.busy); end
    endtask

    task automatic test_pipe_held();
        int lat;
        mode1 = 2'd2;
        if1.start = 1'b1;
        tick();
        tests_run++;
        if (if1.busy !== 1'b1) begin tests_failed++; $display("FAIL pipe_accept: got busy=%b want 1", if1.busy); end
        wait_done(1'b1, lat);
        tests_run++;
        if (lat !== 33) begin tests_failed++; $display("FAIL pipe_latency: got %0d want 33", lat); end
        tests_run++;
        if (if1.err_count !== 9'd80 || if1.err_mask !== 8'h1F || if1.perfect !== 1'b0)
            begin tests_failed++; $display("FAIL pipe_results: got err=%0d mask=%h perfect=%b want 80 1f 0", if1.err_count, if1.err_mask, if1.perfect); end
        tick();
        tests_run++;
        if (if1.busy !== 1'b0 || if1.done !== 1'b0 || if1.err_count !== 9'd80)
            begin tests_failed++; $display("FAIL pipe_idle_cycle: got busy=%b done=%b err=%0d want 0 0 80", if1.busy, if1.done, if1.err_count); end
        tick();
        tests_run++;
        if (if1.busy !== 1'b1 || if1.err_count !== 9'd0)
            begin tests_failed++; $display("FAIL pipe_restart: got busy=%b err=%0d want 1 0", if1.busy, if1.err_count); end
        wait_done(1'b1, lat);
        if1.start = 1'b0;
        tests_run++;
        if (lat !== 33 || if1.err_count !== 9'd80 || if1.err_mask !== 8'h1F)
            begin tests_failed++; $display("FAIL pipe_second: got lat=%0d err=%0d mask=%h want 33 80 1f", lat, if1.err_count, if1.err_mask); end
        tick();
        tick();
        tick();
        tests_run++;
        if (if1.busy !== 1'b0) begin tests_failed++; $display("FAIL pipe_stop: got busy=%b want 0", if1.busy); end
    endtask

    task automatic test_ignored_start();
        int lat;
        mode0 = 2'd1;
        accept0();
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            if0.start = ((n - 1) == 5) || ((n - 1) == 20);
            tick();
            if (if0.done === 1'b1) begin
                lat = n;
                break;
            end
        end
        if0.start = 1'b0;
        tests_run++;
        if (lat !== 32) begin tests_failed++; $display("FAIL ignore_latency: got %0d want 32", lat); end
        tests_run++;
        if (if0.err_count !== 9'd32 || if0.err_mask !== 8'h01)
            begin tests_failed++; $display("FAIL ignore_results: got err=%0d mask=%h want 32 01", if0.err_count, if0.err_mask); end
        if0.start = 1'b1;
        tick();
        if0.start = 1'b0;
        tests_run++;
        if (if0.busy !== 1'b0 || if0.done !== 1'b0)
            begin tests_failed++; $display("FAIL ignore_done_start: got busy=%b done=%b want 0 0", if0.busy, if0.done); end
        tick();
        tests_run++;
        if (if0.busy !== 1'b0 || if0.err_count !== 9'd32)
            begin tests_failed++; $display("FAIL ignore_still_idle: got busy=%b err=%0d want 0 32", if0.busy, if0.err_count); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        mode0        = 2'd0;
        mode1        = 2'd0;
        if0.start    = 1'b0;
        if1.start    = 1'b0;
        #1;
        test_reset();
        test_perfect();
        test_const_err();
        test_ramp();
        test_rst_mid();
        test_pipe_held();
        test_ignored_start();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
